// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared RISC-V immediate classes, opcodes and fetch states
// Purpose: types and constants shared by the fetch/decode stage, the opcode
//   classifier and the immediate sign extender.
// Ports: none (package).
package riscv_pkg;

  typedef enum logic [2:0] {
    IMM_I    = 3'b000,
    IMM_S    = 3'b001,
    IMM_SB   = 3'b010,
    IMM_UJ   = 3'b011,
    IMM_U    = 3'b100,
    IMM_NONE = 3'b111
  } imm_type_e;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_MEM,
    HOLD
  } fetch_state_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_IMM32  = 7'b0011011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_REG32  = 7'b0111011;

endpackage

// File: rtl/opcode_classify.sv
// rtl/opcode_classify.sv - combinational opcode to immediate-class decoder
// Purpose: maps a 7-bit opcode to its immediate class and flags opcodes
//   that are not supported.
// Ports: opcode (in, 7); instr_type (out, imm_type_e); illegal (out, 1).
module opcode_classify
  import riscv_pkg::*;
(
  input  logic [6:0] opcode,
  output imm_type_e  instr_type,
  output logic       illegal
);

  always_comb begin
    instr_type = IMM_NONE;
    illegal    = 1'b0;
    case (opcode)
      OP_LOAD, OP_IMM, OP_IMM32, OP_JALR, OP_SYSTEM: instr_type = IMM_I;
      OP_STORE:                                      instr_type = IMM_S;
      OP_BRANCH:                                     instr_type = IMM_SB;
      OP_JAL:                                        instr_type = IMM_UJ;
      OP_LUI, OP_AUIPC:                              instr_type = IMM_U;
      OP_REG, OP_REG32:                              instr_type = IMM_NONE;
      default:                                       illegal    = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_fetch_decode.sv
// rtl/instr_fetch_decode.sv - instruction register and registered pre-decoder
// Purpose: fetches one 32-bit instruction per fetch_start over a
//   variable-latency memory handshake, holds it, and drives registered
//   decode outputs to the sign extender and control.
// Ports: clock, reset (async, active-low); fetch_start, flush (control);
//   mem_rd, mem_rdata, mem_valid (memory); Instr31_0, InstrType, rs1, rs2,
//   rd, funct3, instr_valid, illegal (decode); mem_err (sticky timeout).
module instr_fetch_decode
  import riscv_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 16,
  parameter logic [31:0] NOP_INSTR   = 32'h00000013
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        fetch_start,
  input  logic        flush,
  output logic        mem_rd,
  input  logic [31:0] mem_rdata,
  input  logic        mem_valid,
  output logic [31:0] Instr31_0,
  output logic [2:0]  InstrType,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [4:0]  rd,
  output logic [2:0]  funct3,
  output logic        instr_valid,
  output logic        illegal,
  output logic        mem_err
);

  // Counter only needs to reach TIMEOUT_CYC-1: the timeout fires on the edge
  // that would make it TIMEOUT_CYC.
  localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYC - 1);

  fetch_state_e  state_q, state_d;
  logic [31:0]   instr_q, instr_d;
  imm_type_e     type_q, type_d;
  logic          illegal_q, illegal_d;
  logic          err_q, err_d;
  logic [CW-1:0] cnt_q, cnt_d;

  imm_type_e     cls_type;
  logic          cls_illegal;

  opcode_classify u_classify (
    .opcode     (mem_rdata[6:0]),
    .instr_type (cls_type),
    .illegal    (cls_illegal)
  );

  always_comb begin
    state_d   = state_q;
    instr_d   = instr_q;
    type_d    = type_q;
    illegal_d = illegal_q;
    err_d     = err_q;
    cnt_d     = cnt_q;
    if (flush) begin
      state_d   = IDLE;
      instr_d   = NOP_INSTR;
      type_d    = IMM_I;
      illegal_d = 1'b0;
      err_d     = 1'b0;
      cnt_d     = '0;
    end else begin
      case (state_q)
        IDLE, HOLD: begin
          if (fetch_start) begin
            state_d = WAIT_MEM;
            err_d   = 1'b0;
            cnt_d   = '0;
          end
        end
        WAIT_MEM: begin
          // mem_valid is checked first so data arriving on the last allowed
          // cycle wins over the timeout.
          if (mem_valid) begin
            state_d   = HOLD;
            instr_d   = mem_rdata;
            type_d    = cls_type;
            illegal_d = cls_illegal;
          end else if (TIMEOUT_CYC != 0) begin
            if (cnt_q == CNT_LAST) begin
              state_d = IDLE;
              err_d   = 1'b1;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      instr_q   <= NOP_INSTR;
      type_q    <= IMM_I;
      illegal_q <= 1'b0;
      err_q     <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      instr_q   <= instr_d;
      type_q    <= type_d;
      illegal_q <= illegal_d;
      err_q     <= err_d;
      cnt_q     <= cnt_d;
    end
  end

  assign mem_rd      = (state_q == WAIT_MEM);
  assign instr_valid = (state_q == HOLD);
  assign Instr31_0   = instr_q;
  assign InstrType   = type_q;
  assign illegal     = illegal_q;
  assign mem_err     = err_q;
  assign rs1         = instr_q[19:15];
  assign rs2         = instr_q[24:20];
  assign rd          = instr_q[11:7];
  assign funct3      = instr_q[14:12];

endmodule

// File: tb/tb_instr_fetch_decode.sv
// tb/tb_instr_fetch_decode.sv - self-checking bench for instr_fetch_decode
module tb_instr_fetch_decode;

  localparam int          T   = 4;
  localparam logic [31:0] NOP = 32'h00000013;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        fetch_start = 1'b0;
  logic        flush = 1'b0;
  logic        mem_rd;
  logic [31:0] mem_rdata = 32'h0;
  logic        mem_valid = 1'b0;
  logic [31:0] Instr31_0;
  logic [2:0]  InstrType;
  logic [4:0]  rs1, rs2, rd;
  logic [2:0]  funct3;
  logic        instr_valid, illegal, mem_err;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  bit chk_en   = 1'b0;

  instr_fetch_decode #(.TIMEOUT_CYC(T), .NOP_INSTR(NOP)) dut (
    .clock       (clock),
    .reset       (reset),
    .fetch_start (fetch_start),
    .flush       (flush),
    .mem_rd      (mem_rd),
    .mem_rdata   (mem_rdata),
    .mem_valid   (mem_valid),
    .Instr31_0   (Instr31_0),
    .InstrType   (InstrType),
    .rs1         (rs1),
    .rs2         (rs2),
    .rd          (rd),
    .funct3      (funct3),
    .instr_valid (instr_valid),
    .illegal     (illegal),
    .mem_err     (mem_err)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at t=%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Reference opcode table.
  logic [6:0] op_tab [12] = '{7'h03, 7'h13, 7'h1B, 7'h67, 7'h73, 7'h23,
                              7'h63, 7'h6F, 7'h37, 7'h17, 7'h33, 7'h3B};
  logic [2:0] ty_tab [12] = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd1,
                              3'd2, 3'd3, 3'd4, 3'd4, 3'd7, 3'd7};

  function automatic void ref_decode(input logic [31:0] w, output logic [2:0] t, output bit ill);
    t   = 3'd7;
    ill = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if ((w % 128) == 32'(op_tab[i])) begin
        t   = ty_tab[i];
        ill = 1'b0;
      end
    end
  endfunction

  // Behavioural model: a fetch is outstanding (m_busy) for at most T cycles;
  // the held word and its validity change only when a fetch completes,
  // times out, or is flushed.
  bit          m_busy  = 1'b0;
  int          m_wait  = 0;
  logic [31:0] m_instr = NOP;
  bit          m_valid = 1'b0;
  bit          m_err   = 1'b0;

  always @(posedge clock or negedge reset) begin
    if (!reset || flush) begin
      m_busy = 0; m_wait = 0; m_instr = NOP; m_valid = 0; m_err = 0;
    end else if (m_busy) begin
      m_wait = m_wait + 1;
      if (mem_valid) begin
        m_busy = 0; m_instr = mem_rdata; m_valid = 1;
      end else if (m_wait == T) begin
        m_busy = 0; m_err = 1;
      end
    end else if (fetch_start) begin
      m_busy = 1; m_wait = 0; m_valid = 0; m_err = 0;
    end
  end

  always @(negedge clock) begin
    logic [2:0] et;
    bit         ei;
    if (chk_en) begin
      ref_decode(m_instr, et, ei);
      chk("mem_rd",      32'(mem_rd),      32'(m_busy));
      chk("instr_valid", 32'(instr_valid), 32'(m_valid));
      chk("mem_err",     32'(mem_err),     32'(m_err));
      chk("Instr31_0",   Instr31_0,        m_instr);
      chk("InstrType",   32'(InstrType),   32'(et));
      chk("illegal",     32'(illegal),     32'(ei));
      chk("rs1",         32'(rs1),         (m_instr >> 15) % 32);
      chk("rs2",         32'(rs2),         (m_instr >> 20) % 32);
      chk("rd",          32'(rd),          (m_instr >> 7) % 32);
      chk("funct3",      32'(funct3),      (m_instr >> 12) % 8);
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_fetch(input logic [31:0] w, input int waits);
    fetch_start = 1; step(); fetch_start = 0;
    repeat (waits) step();
    mem_valid = 1; mem_rdata = w; step();
    mem_valid = 0; mem_rdata = $urandom;
  endtask

  initial begin
    int c0;
    repeat (2) step();
    chk("reset_instr", Instr31_0, NOP);
    chk("reset_valid", 32'(instr_valid), 0);
    chk("reset_memrd", 32'(mem_rd), 0);
    reset = 1; chk_en = 1;
    step();

    // Zero-wait fetch: valid two cycles after fetch_start.
    c0 = cyc;
    do_fetch(32'hFFF00093, 0);
    chk("zw_latency", 32'(cyc - c0), 2);
    chk("zw_valid", 32'(instr_valid), 1);
    chk("zw_type", 32'(InstrType), 0);
    chk("zw_rd", 32'(rd), 1);
    chk("zw_rs1", 32'(rs1), 0);
    chk("zw_illegal", 32'(illegal), 0);
    step();

    // Three wait cycles on a branch: valid on cycle 5.
    c0 = cyc;
    fetch_start = 1; step(); fetch_start = 0;
    repeat (3) step();
    chk("beq_notyet", 32'(instr_valid), 0);
    mem_valid = 1; mem_rdata = 32'h00208463; step(); mem_valid = 0;
    chk("beq_latency", 32'(cyc - c0), 5);
    chk("beq_type", 32'(InstrType), 2);
    chk("beq_rs1", 32'(rs1), 1);
    chk("beq_rs2", 32'(rs2), 2);
    chk("beq_f3", 32'(funct3), 0);

    do_fetch(32'h0000006F, 1);
    chk("jal_type", 32'(InstrType), 3);
    do_fetch(32'h0000007F, 2);
    chk("ill_flag", 32'(illegal), 1);
    chk("ill_type", 32'(InstrType), 7);
    chk("ill_valid", 32'(instr_valid), 1);
    do_fetch(32'h002081B3, 0);
    chk("add_type", 32'(InstrType), 7);
    chk("add_illegal", 32'(illegal), 0);

    // Timeout after T wait cycles; held word unchanged.
    fetch_start = 1; step(); fetch_start = 0;
    repeat (T - 1) step();
    chk("to_pending_rd", 32'(mem_rd), 1);
    chk("to_pending_err", 32'(mem_err), 0);
    step();
    chk("to_err", 32'(mem_err), 1);
    chk("to_memrd", 32'(mem_rd), 0);
    chk("to_instr", Instr31_0, 32'h002081B3);
    fetch_start = 1; step(); fetch_start = 0;
    chk("to_clear", 32'(mem_err), 0);
    // mem_valid on the last allowed wait cycle is accepted.
    repeat (T - 1) step();
    mem_valid = 1; mem_rdata = 32'h00000023; step(); mem_valid = 0;
    chk("edge_valid", 32'(instr_valid), 1);
    chk("edge_err", 32'(mem_err), 0);
    chk("edge_type", 32'(InstrType), 1);

    // Flush racing mem_valid.
    fetch_start = 1; step(); fetch_start = 0;
    flush = 1; mem_valid = 1; mem_rdata = 32'h00000037; step();
    flush = 0; mem_valid = 0;
    chk("fl_mv_valid", 32'(instr_valid), 0);
    chk("fl_mv_instr", Instr31_0, NOP);
    // Flush racing fetch_start.
    flush = 1; fetch_start = 1; step(); flush = 0; fetch_start = 0;
    chk("fl_fs_memrd", 32'(mem_rd), 0);
    step();
    chk("fl_fs_memrd2", 32'(mem_rd), 0);

    // Asynchronous reset mid-fetch, then a stray mem_valid.
    do_fetch(32'h00000017, 0);
    fetch_start = 1; step(); fetch_start = 0;
    #2 reset = 0; #1;
    chk("rst_instr", Instr31_0, NOP);
    chk("rst_valid", 32'(instr_valid), 0);
    chk("rst_memrd", 32'(mem_rd), 0);
    step();
    reset = 1; mem_valid = 1; mem_rdata = 32'h00000067; step(); mem_valid = 0;
    chk("rst_stray", 32'(instr_valid), 0);

    // Random traffic checked every cycle by the model.
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] w;
      w = $urandom;
      if ($urandom_range(3) != 0) w[6:0] = op_tab[$urandom_range(11)];
      fetch_start = ($urandom_range(5) == 0);
      flush       = ($urandom_range(39) == 0);
      mem_valid   = ($urandom_range(2) == 0);
      mem_rdata   = w;
      step();
    end
    fetch_start = 0; flush = 0; mem_valid = 0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
